cdc_hs_rx_endpoint: RTL and testbench
=====================================

Name: cdc_hs_rx_endpoint

Overview:
- Destination-domain receiver for a 4-phase req/ack CDC data bus.
- Source side raises a level request while holding a DATA_W-bit word stable. This block synchronises the request, captures the word, returns a level acknowledge, and buffers captured words in a first-word-fall-through FIFO.
- Downstream logic reads the FIFO through a valid/ready port in dst_clk.

Parameters:
- DATA_W, 8, width of the transferred word.
- SYNC_STAGES, 2, flops in the request synchroniser; legal values 2..4.
- FIFO_DEPTH, 4, receive buffer entries; power of 2, minimum 2.

Ports:
- dst_clk  input  1  destination clock.
- dst_rst_n  input  1  reset, asynchronous, active-low; clock dst_clk.
- src_req_a  input  1  request level from the source domain; asynchronous to dst_clk.
- src_data_a  input  DATA_W  source data; stable while src_req_a=1 and until rx_ack is seen high by the source.
- rx_ack  output  1  acknowledge level to the source domain; driven directly from a dst_clk flop, no logic after the flop.
- m_vld  output  1  FIFO non-empty.
- m_data  output  DATA_W  FIFO head word; valid when m_vld=1.
- m_rdy  input  1  downstream accept; a pop occurs when m_vld & m_rdy.
- fifo_level  output  clog2(FIFO_DEPTH)+1  current occupancy.
- proto_err  output  1  sticky protocol-violation flag.

Behaviour:

Reset:
- rx_ack=0, m_vld=0, m_data=0, fifo_level=0, proto_err=0.
- Synchroniser flops=0, FSM=IDLE, pointers=0, storage=0.

Synchroniser:
- src_req_a passes through SYNC_STAGES flops; the last-stage output is req_s.
- src_data_a is never synchronised. It is sampled only on the capture edge, when req_s=1 guarantees stability.

FSM, three states, registered:
- IDLE (rx_ack=0):
  - req_s=1 and !full: write src_data_a into FIFO, rx_ack<=1, go to ACK.
  - req_s=1 and full: go to STALL.
  - Otherwise stay in IDLE.
- STALL (rx_ack=0):
  - !full: capture as above, go to ACK.
  - req_s=0: go to IDLE with no capture, set proto_err.
- ACK (rx_ack=1):
  - req_s=0: rx_ack<=0, go to IDLE.
  - Otherwise hold.

Handshake rules:
- Exactly one FIFO write per request rising edge.
- A new write cannot occur until req_s has returned to 0 and the FSM has re-entered IDLE.
- In IDLE, the FSM does not act on req_s=1 that arrives in the same cycle it returns to IDLE. It acts from the next cycle, which is naturally satisfied because req_s must first be seen low.

Full condition and latency:
- full = (fifo_level==FIFO_DEPTH), taken from the registered level only.
- A pop in the same cycle does not make space for a capture in that cycle. The capture occurs on the following edge. There is no combinational path from m_rdy to rx_ack.
- Latency: if src_req_a is first sampled high at edge E0, req_s=1 after edge E0+SYNC_STAGES-1. Capture and rx_ack rise occur at edge E0+SYNC_STAGES, and m_vld=1 is visible after that same edge when the FIFO was empty.
- rx_ack falls SYNC_STAGES edges after src_req_a is first sampled low.

FIFO:
- Circular buffer with wr_ptr/rd_ptr of clog2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH.
- m_data = mem[rd_ptr], combinational read of registered storage (FWFT).
- m_vld = (fifo_level!=0).
- Push only: level+1. Pop only: level-1. Simultaneous push and pop: level unchanged and both pointers advance.
- A pop while empty is impossible, since a pop requires m_vld=1.
- A push while full is impossible by construction.

proto_err:
- Set only by a req drop in STALL.
- Cleared only by reset.

Reset mid-operation:
- Any state returns to IDLE and the buffered data is discarded.
- rx_ack drops asynchronously with reset.

Test Plan:
- Single word: after reset, hold src_data_a=0xA5 and raise src_req_a. Required: rx_ack=1 exactly 2 dst_clk edges later (SYNC_STAGES=2), m_vld=1, m_data=0xA5. Drop req: rx_ack=0 2 edges after the drop.
- Burst without pops: run 4 handshakes with data 0x01..0x04 and m_rdy=0 → fifo_level=4. Start a 5th request with 0x05 → FSM in STALL, rx_ack stays 0. Assert m_rdy for 1 cycle → pop 0x01, capture 0x05 on the next edge, rx_ack=1. Drain order must be 0x02,0x03,0x04,0x05.
- Simultaneous push/pop: level=1 and m_rdy=1 on the capture edge → fifo_level stays 1. Pointers wrap correctly over 10 consecutive transfers, and read data matches write order.
- Protocol violation: fill the FIFO, raise req, then drop req while in STALL → proto_err=1, no write, fifo_level=4. proto_err stays 1 through subsequent normal transfers.
- Reset mid-handshake: assert dst_rst_n=0 while in ACK with level=2 → rx_ack=0, m_vld=0, fifo_level=0 immediately. After release with req held low, a new transfer of 0x3C completes normally.
- Random stress: random req timing obeying 4-phase rules, random m_rdy, with dst_clk/src period ratios 1:3 and 3:1 → 1000 words delivered in order, no loss or duplication, proto_err=0.

Source files
------------

// File: rtl/cdc_hs_rx_endpoint.sv
// Destination-side endpoint of a 4-phase req/ack CDC bus.
// It synchronises the request, captures the word into a FWFT FIFO and returns a level ack.
`timescale 1ns/1ps
module cdc_hs_rx_endpoint #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int LW = PW + 1
) (
  input  logic              dst_clk,
  input  logic              dst_rst_n,
  input  logic              src_req_a,
  input  logic [DATA_W-1:0] src_data_a,
  output logic              rx_ack,
  output logic              m_vld,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_rdy,
  output logic [LW-1:0]     fifo_level,
  output logic              proto_err
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be 2..4");
  end
  if (FIFO_DEPTH < 2 || (1 << PW) != FIFO_DEPTH) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2, >= 2");
  end

  typedef enum logic [1:0] {IDLE, STALL, ACK} state_t;

  logic [SYNC_STAGES-1:0]             sync_q;
  logic                               req_s;
  state_t                             state;
  logic [FIFO_DEPTH-1:0][DATA_W-1:0]  mem;
  logic [PW-1:0]                      wr_ptr, rd_ptr;
  logic                               full, push, pop;

  always_ff @(posedge dst_clk or negedge dst_rst_n) begin
    if (!dst_rst_n) sync_q <= '0;
    else            sync_q <= {sync_q[SYNC_STAGES-2:0], src_req_a};
  end
  assign req_s = sync_q[SYNC_STAGES-1];

  // full comes from the registered level only, so a same-cycle pop never
  // opens a slot for a capture: no path from m_rdy to rx_ack.
  assign full = (fifo_level == LW'(FIFO_DEPTH));
  assign pop  = m_vld & m_rdy;

  // A request that drops while stalled must not be captured: the data is
  // no longer guaranteed stable, so req_s gates every write.
  always_comb begin
    push = 1'b0;
    if (state != ACK && req_s && !full) push = 1'b1;
  end

  always_ff @(posedge dst_clk or negedge dst_rst_n) begin
    if (!dst_rst_n) begin
      state     <= IDLE;
      rx_ack    <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (push) begin
            rx_ack <= 1'b1;
            state  <= ACK;
          end else if (req_s) begin
            state  <= STALL;
          end
        end
        STALL: begin
          if (!req_s) begin
            proto_err <= 1'b1;
            state     <= IDLE;
          end else if (push) begin
            rx_ack <= 1'b1;
            state  <= ACK;
          end
        end
        ACK: begin
          if (!req_s) begin
            rx_ack <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          rx_ack <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge dst_clk or negedge dst_rst_n) begin
    if (!dst_rst_n) begin
      mem        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= src_data_a;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  assign m_vld  = (fifo_level != '0);
  assign m_data = mem[rd_ptr];

endmodule

// File: tb/tb_cdc_hs_rx_endpoint.sv
// Directed + random bench for cdc_hs_rx_endpoint; a scoreboard queue holds words
// in send order and a negedge monitor checks every popped word against it.
`timescale 1ns/1ps
module tb_cdc_hs_rx_endpoint;
  localparam int DW = 8;
  localparam int SS = 2;
  localparam int FD = 4;
  localparam int LW = 3;

  logic          dst_clk = 1'b0;
  logic          dst_rst_n = 1'b1;
  logic          src_req_a = 1'b0;
  logic [DW-1:0] src_data_a = '0;
  logic          m_rdy = 1'b0;
  logic          rx_ack, m_vld, proto_err;
  logic [DW-1:0] m_data;
  logic [LW-1:0] fifo_level;

  int checks = 0;
  int errors = 0;
  int delivered = 0;
  bit done = 1'b0;
  logic [DW-1:0] exp_q[$];

  cdc_hs_rx_endpoint #(.DATA_W(DW), .SYNC_STAGES(SS), .FIFO_DEPTH(FD)) dut (
    .dst_clk(dst_clk), .dst_rst_n(dst_rst_n), .src_req_a(src_req_a),
    .src_data_a(src_data_a), .rx_ack(rx_ack), .m_vld(m_vld), .m_data(m_data),
    .m_rdy(m_rdy), .fifo_level(fifo_level), .proto_err(proto_err)
  );

  always #5 dst_clk = ~dst_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop happens on the next posedge when m_vld & m_rdy are high now.
  always @(negedge dst_clk) begin
    if (dst_rst_n && m_vld && m_rdy) begin
      if (exp_q.size() == 0) chk("pop_unexpected", {31'd0, m_vld}, 32'd0);
      else begin
        chk("pop_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
        delivered++;
      end
    end
  end

  task automatic tick();
    @(posedge dst_clk);
    #1;
  endtask

  task automatic hs(input logic [DW-1:0] d);
    int n;
    src_data_a = d;
    src_req_a  = 1'b1;
    exp_q.push_back(d);
    n = 0;
    while (!rx_ack && n < 50) begin tick(); n++; end
    chk("hs_ack_rise", {31'd0, rx_ack}, 32'd1);
    src_req_a = 1'b0;
    n = 0;
    while (rx_ack && n < 50) begin tick(); n++; end
    chk("hs_ack_fall", {31'd0, rx_ack}, 32'd0);
  endtask

  task automatic drain();
    int n;
    m_rdy = 1'b1;
    n = 0;
    while (m_vld && n < 50) begin tick(); n++; end
    m_rdy = 1'b0;
    chk("drain_empty", {29'd0, fifo_level}, 32'd0);
  endtask

  // Source-domain transfer with its own time base, asynchronous to dst_clk.
  task automatic src_xfer(input logic [DW-1:0] d, input realtime per);
    int n;
    #($urandom_range(0, 9));
    src_data_a = d;
    #per;
    src_req_a = 1'b1;
    exp_q.push_back(d);
    n = 0;
    while (!rx_ack && n < 4000) begin #per; n++; end
    chk("rnd_ack_rise", {31'd0, rx_ack}, 32'd1);
    src_req_a = 1'b0;
    n = 0;
    while (rx_ack && n < 4000) begin #per; n++; end
    chk("rnd_ack_fall", {31'd0, rx_ack}, 32'd0);
    #(per * $urandom_range(0, 3));
  endtask

  initial begin
    int base;
    int n;
    #1 dst_rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_ack", {31'd0, rx_ack}, 32'd0);
    chk("rst_vld", {31'd0, m_vld}, 32'd0);
    chk("rst_data", {24'd0, m_data}, 32'd0);
    chk("rst_level", {29'd0, fifo_level}, 32'd0);
    chk("rst_perr", {31'd0, proto_err}, 32'd0);
    dst_rst_n = 1'b1;
    repeat (2) tick();

    // single word latency
    src_data_a = 8'hA5;
    src_req_a  = 1'b1;
    exp_q.push_back(8'hA5);
    tick(); tick();
    chk("lat_ack_early", {31'd0, rx_ack}, 32'd0);
    tick();
    chk("lat_ack_rise", {31'd0, rx_ack}, 32'd1);
    chk("lat_vld", {31'd0, m_vld}, 32'd1);
    chk("lat_data", {24'd0, m_data}, 32'hA5);
    chk("lat_level", {29'd0, fifo_level}, 32'd1);
    src_req_a = 1'b0;
    tick(); tick();
    chk("lat_ack_hold", {31'd0, rx_ack}, 32'd1);
    tick();
    chk("lat_ack_fall", {31'd0, rx_ack}, 32'd0);
    drain();

    // burst into full FIFO, stall, single pop releases the stalled capture
    for (int i = 1; i <= 4; i++) hs(DW'(i));
    chk("burst_level4", {29'd0, fifo_level}, 32'd4);
    src_data_a = 8'h05;
    src_req_a  = 1'b1;
    exp_q.push_back(8'h05);
    repeat (6) tick();
    chk("stall_no_ack", {31'd0, rx_ack}, 32'd0);
    chk("stall_level", {29'd0, fifo_level}, 32'd4);
    m_rdy = 1'b1;
    tick();
    m_rdy = 1'b0;
    chk("stall_pop_no_same_cycle", {31'd0, rx_ack}, 32'd0);
    chk("stall_pop_level", {29'd0, fifo_level}, 32'd3);
    tick();
    chk("stall_capture_ack", {31'd0, rx_ack}, 32'd1);
    chk("stall_capture_level", {29'd0, fifo_level}, 32'd4);
    src_req_a = 1'b0;
    n = 0;
    while (rx_ack && n < 50) begin tick(); n++; end
    chk("stall_ack_fall", {31'd0, rx_ack}, 32'd0);
    drain();

    // simultaneous push/pop at level 1
    hs(8'h11);
    src_data_a = 8'h22;
    src_req_a  = 1'b1;
    exp_q.push_back(8'h22);
    tick(); tick();
    m_rdy = 1'b1;
    tick();
    chk("pushpop_ack", {31'd0, rx_ack}, 32'd1);
    chk("pushpop_level", {29'd0, fifo_level}, 32'd1);
    src_req_a = 1'b0;
    n = 0;
    while (rx_ack && n < 50) begin tick(); n++; end
    for (int i = 0; i < 10; i++) hs(DW'(i * 37 + 3));
    drain();
    chk("wrap_q_empty", exp_q.size(), 32'd0);

    // protocol violation: req dropped while stalled
    for (int i = 0; i < 4; i++) hs(DW'(8'h40 + i));
    src_data_a = 8'h77;
    src_req_a  = 1'b1;
    repeat (5) tick();
    chk("perr_stall_ack", {31'd0, rx_ack}, 32'd0);
    src_req_a = 1'b0;
    repeat (5) tick();
    chk("perr_set", {31'd0, proto_err}, 32'd1);
    chk("perr_level", {29'd0, fifo_level}, 32'd4);
    chk("perr_ack", {31'd0, rx_ack}, 32'd0);
    drain();
    hs(8'h99);
    drain();
    chk("perr_sticky", {31'd0, proto_err}, 32'd1);

    // reset while in ACK with two words buffered
    hs(8'h11);
    src_data_a = 8'h22;
    src_req_a  = 1'b1;
    n = 0;
    while (!rx_ack && n < 50) begin tick(); n++; end
    chk("rmid_ack", {31'd0, rx_ack}, 32'd1);
    chk("rmid_level", {29'd0, fifo_level}, 32'd2);
    #2 dst_rst_n = 1'b0;
    #1;
    chk("rmid_ack_async", {31'd0, rx_ack}, 32'd0);
    chk("rmid_vld_async", {31'd0, m_vld}, 32'd0);
    chk("rmid_level_async", {29'd0, fifo_level}, 32'd0);
    chk("rmid_perr_clr", {31'd0, proto_err}, 32'd0);
    src_req_a = 1'b0;
    exp_q.delete();
    repeat (3) tick();
    #2 dst_rst_n = 1'b1;
    tick(); tick();
    hs(8'h3C);
    chk("rmid_new_vld", {31'd0, m_vld}, 32'd1);
    chk("rmid_new_data", {24'd0, m_data}, 32'h3C);
    drain();

    // random stress, source period 3x and 1/3x the dst period
    base = delivered;
    for (int r = 0; r < 2; r++) begin
      done = 1'b0;
      fork
        begin
          for (int w = 0; w < 500; w++)
            src_xfer(DW'($urandom_range(0, 255)), (r == 0) ? 30.0 : 3.3);
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(posedge dst_clk);
            #1 m_rdy = 1'($urandom_range(0, 1));
          end
        end
      join
      drain();
    end
    chk("stress_delivered", delivered - base, 32'd1000);
    chk("stress_q_empty", exp_q.size(), 32'd0);
    chk("stress_perr", {31'd0, proto_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
